memwb_reg: RTL and testbench

- MEM/WB pipeline register: latches every MEM-stage result and hands it to the write-back stage.
- Holds the synchronous data-RAM read word stable while write-back is stalled.
- Handles flush, stall and bubble insertion.
- Keeps a retired-instruction counter for the debug/perf path.

---
 rtl/memwb_reg_pkg.sv | 25 ++
 rtl/memwb_reg_if.sv | 55 +++++
 rtl/memwb_reg_dm_hold.sv | 47 ++++
 rtl/memwb_reg.sv | 111 +++++++++++
 tb/tb_memwb_reg.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/memwb_reg_pkg.sv
// Shared bus widths and enable constants for the MEM/WB pipeline register.
package memwb_reg_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_W        = 32;
    localparam int DOUBLE_REG_W = 64;
    localparam int BSEL_W       = 4;

    typedef logic [REG_ADDR_W-1:0]   reg_addr_bus_t;
    typedef logic [REG_W-1:0]        reg_bus_t;
    typedef logic [DOUBLE_REG_W-1:0] double_reg_bus_t;
    typedef logic [BSEL_W-1:0]       bsel_bus_t;

    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;

    localparam logic WRITE_ENABLE   = 1'b1;
    localparam logic WRITE_DISABLE  = 1'b0;
    localparam logic MREG_ENABLE    = 1'b1;
    localparam logic MREG_DISABLE   = 1'b0;
    localparam logic WHILO_ENABLE   = 1'b1;
    localparam logic WHILO_DISABLE  = 1'b0;
    localparam logic CP0_WE_ENABLE  = 1'b1;
    localparam logic CP0_WE_DISABLE = 1'b0;

endpackage

// File: rtl/memwb_reg_if.sv
// MEM-side inputs and WB-side outputs of the MEM/WB register; master = MEM stage, slave = register.
interface memwb_reg_if
    import memwb_reg_pkg::*;
#(
    parameter int DRE_W  = 4,
    parameter int HILO_W = 64,
    parameter int CNT_W  = 32
) ();

    logic              mem_valid;
    reg_addr_bus_t     mem_wa;
    logic              mem_wreg;
    reg_bus_t          mem_dreg;
    logic              mem_mreg;
    logic [DRE_W-1:0]  mem_dre;
    logic              mem_sign;
    logic              mem_whilo;
    logic [HILO_W-1:0] mem_hilo;
    logic              mem_cp0_we;
    reg_addr_bus_t     mem_cp0_waddr;
    reg_bus_t          mem_cp0_wdata;
    reg_bus_t          dm_i;

    logic              wb_valid_o;
    reg_addr_bus_t     wb_wa_o;
    logic              wb_wreg_o;
    reg_bus_t          wb_dreg_o;
    logic              wb_mreg_o;
    logic [DRE_W-1:0]  wb_dre_o;
    logic              wb_sign_o;
    logic              wb_whilo_o;
    logic [HILO_W-1:0] wb_hilo_o;
    logic              wb_cp0_we_o;
    reg_addr_bus_t     wb_cp0_waddr_o;
    reg_bus_t          wb_cp0_wdata_o;
    reg_bus_t          dm_o;
    logic [CNT_W-1:0]  retired_o;

    modport master (
        output mem_valid, mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_sign,
               mem_whilo, mem_hilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata, dm_i,
        input  wb_valid_o, wb_wa_o, wb_wreg_o, wb_dreg_o, wb_mreg_o, wb_dre_o, wb_sign_o,
               wb_whilo_o, wb_hilo_o, wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_wdata_o,
               dm_o, retired_o
    );

    modport slave (
        input  mem_valid, mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_sign,
               mem_whilo, mem_hilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata, dm_i,
        output wb_valid_o, wb_wa_o, wb_wreg_o, wb_dreg_o, wb_mreg_o, wb_dre_o, wb_sign_o,
               wb_whilo_o, wb_hilo_o, wb_cp0_we_o, wb_cp0_waddr_o, wb_cp0_wdata_o,
               dm_o, retired_o
    );

endinterface

// File: rtl/memwb_reg_dm_hold.sv
// Freezes the synchronous data-RAM read word while write-back is stalled.
module memwb_dm_hold
    import memwb_reg_pkg::*;
(
    input  logic     cpu_clk_50M,
    input  logic     cpu_rst,
    input  logic     flush,
    input  logic     stall_wb,
    input  reg_bus_t dm_i,
    output reg_bus_t dm_o
);

    reg_bus_t buf_d, buf_q;
    logic     hold_d, hold_q;

    // Capture only on the first stalled edge; later stalled edges keep the captured word.
    always_comb begin
        buf_d  = buf_q;
        hold_d = hold_q;
        if (flush) begin
            hold_d = 1'b0;
        end else if (stall_wb) begin
            if (!hold_q) begin
                buf_d  = dm_i;
                hold_d = 1'b1;
            end else begin
                hold_d = 1'b1;
            end
        end else begin
            hold_d = 1'b0;
        end
    end

    // Buffer and hold-flag registers.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            buf_q  <= ZERO_WORD;
            hold_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            hold_q <= hold_d;
        end
    end

    assign dm_o = hold_q ? buf_q : dm_i;

endmodule

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with flush/stall/bubble handling, load-data hold and retire counter.
module memwb_reg
    import memwb_reg_pkg::*;
#(
    parameter int DRE_W  = 4,
    parameter int HILO_W = 64,
    parameter int CNT_W  = 32
) (
    input logic        cpu_clk_50M,
    input logic        cpu_rst,
    input logic        stall_mem,
    input logic        stall_wb,
    input logic        flush,
    memwb_reg_if.slave bus
);

    typedef struct packed {
        logic              valid;
        reg_addr_bus_t     wa;
        logic              wreg;
        reg_bus_t          dreg;
        logic              mreg;
        logic [DRE_W-1:0]  dre;
        logic              sign;
        logic              whilo;
        logic [HILO_W-1:0] hilo;
        logic              cp0_we;
        reg_addr_bus_t     cp0_waddr;
        reg_bus_t          cp0_wdata;
    } wb_payload_t;

    // A bubble has every write enable off so it can never change architectural state.
    localparam wb_payload_t BUBBLE = '{
        valid: 1'b0, wa: 5'd0, wreg: WRITE_DISABLE, dreg: ZERO_WORD,
        mreg: MREG_DISABLE, dre: {DRE_W{1'b0}}, sign: 1'b0,
        whilo: WHILO_DISABLE, hilo: {HILO_W{1'b0}},
        cp0_we: CP0_WE_DISABLE, cp0_waddr: 5'd0, cp0_wdata: ZERO_WORD
    };
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    wb_payload_t      mem_pay_s, pay_d, pay_q;
    logic [CNT_W-1:0] retired_d, retired_q;
    logic             retire_s;

    assign mem_pay_s = '{
        valid: bus.mem_valid, wa: bus.mem_wa, wreg: bus.mem_wreg, dreg: bus.mem_dreg,
        mreg: bus.mem_mreg, dre: bus.mem_dre, sign: bus.mem_sign,
        whilo: bus.mem_whilo, hilo: bus.mem_hilo,
        cp0_we: bus.mem_cp0_we, cp0_waddr: bus.mem_cp0_waddr, cp0_wdata: bus.mem_cp0_wdata
    };

    // Next payload: flush beats a WB stall, which beats a MEM-only stall.
    always_comb begin
        pay_d = pay_q;
        if (flush) begin
            pay_d = BUBBLE;
        end else if (stall_wb) begin
            pay_d = pay_q;
        end else if (stall_mem) begin
            pay_d = BUBBLE;
        end else begin
            pay_d = mem_pay_s;
        end
    end

    // An instruction retires on the edge it leaves WB unstalled and unflushed.
    always_comb begin
        retire_s  = pay_q.valid & ~stall_wb & ~flush;
        retired_d = retired_q;
        if (retire_s) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end
    end

    // Payload and counter registers.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pay_q     <= BUBBLE;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            pay_q     <= pay_d;
            retired_q <= retired_d;
        end
    end

    memwb_dm_hold u_dm_hold (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .flush       (flush),
        .stall_wb    (stall_wb),
        .dm_i        (bus.dm_i),
        .dm_o        (bus.dm_o)
    );

    assign bus.wb_valid_o     = pay_q.valid;
    assign bus.wb_wa_o        = pay_q.wa;
    assign bus.wb_wreg_o      = pay_q.wreg;
    assign bus.wb_dreg_o      = pay_q.dreg;
    assign bus.wb_mreg_o      = pay_q.mreg;
    assign bus.wb_dre_o       = pay_q.dre;
    assign bus.wb_sign_o      = pay_q.sign;
    assign bus.wb_whilo_o     = pay_q.whilo;
    assign bus.wb_hilo_o      = pay_q.hilo;
    assign bus.wb_cp0_we_o    = pay_q.cp0_we;
    assign bus.wb_cp0_waddr_o = pay_q.cp0_waddr;
    assign bus.wb_cp0_wdata_o = pay_q.cp0_wdata;
    assign bus.retired_o      = retired_q;

endmodule

// File: tb/tb_memwb_reg.sv
// Directed bench for memwb_reg: vector table plus hand-written stall, flush, reset and wrap sequences.
module tb_memwb_reg;
    import memwb_reg_pkg::*;

    logic clk = 1'b0;
    logic rst, sm, sw, fl;
    always #5 clk = ~clk;

    logic        m_valid, m_wreg, m_mreg, m_sign, m_whilo, m_cp0_we;
    logic [4:0]  m_wa, m_cp0_waddr;
    logic [31:0] m_dreg, m_cp0_wdata, m_dm;
    logic [3:0]  m_dre;
    logic [63:0] m_hilo;

    memwb_reg_if #(.DRE_W(4), .HILO_W(64), .CNT_W(32)) bus ();
    memwb_reg_if #(.DRE_W(4), .HILO_W(64), .CNT_W(4))  bus4 ();

    assign bus.mem_valid     = m_valid;     assign bus4.mem_valid     = m_valid;
    assign bus.mem_wa        = m_wa;        assign bus4.mem_wa        = m_wa;
    assign bus.mem_wreg      = m_wreg;      assign bus4.mem_wreg      = m_wreg;
    assign bus.mem_dreg      = m_dreg;      assign bus4.mem_dreg      = m_dreg;
    assign bus.mem_mreg      = m_mreg;      assign bus4.mem_mreg      = m_mreg;
    assign bus.mem_dre       = m_dre;       assign bus4.mem_dre       = m_dre;
    assign bus.mem_sign      = m_sign;      assign bus4.mem_sign      = m_sign;
    assign bus.mem_whilo     = m_whilo;     assign bus4.mem_whilo     = m_whilo;
    assign bus.mem_hilo      = m_hilo;      assign bus4.mem_hilo      = m_hilo;
    assign bus.mem_cp0_we    = m_cp0_we;    assign bus4.mem_cp0_we    = m_cp0_we;
    assign bus.mem_cp0_waddr = m_cp0_waddr; assign bus4.mem_cp0_waddr = m_cp0_waddr;
    assign bus.mem_cp0_wdata = m_cp0_wdata; assign bus4.mem_cp0_wdata = m_cp0_wdata;
    assign bus.dm_i          = m_dm;        assign bus4.dm_i          = m_dm;

    memwb_reg #(.DRE_W(4), .HILO_W(64), .CNT_W(32)) dut (
        .cpu_clk_50M (clk), .cpu_rst (rst), .stall_mem (sm), .stall_wb (sw), .flush (fl), .bus (bus)
    );

    memwb_reg #(.DRE_W(4), .HILO_W(64), .CNT_W(4)) dut4 (
        .cpu_clk_50M (clk), .cpu_rst (rst), .stall_mem (sm), .stall_wb (sw), .flush (fl), .bus (bus4)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        m_valid = 1'b0; m_wa = 5'd0; m_wreg = 1'b0; m_dreg = 32'h0; m_mreg = 1'b0;
        m_dre = 4'h0; m_sign = 1'b0; m_whilo = 1'b0; m_hilo = 64'h0;
        m_cp0_we = 1'b0; m_cp0_waddr = 5'd0; m_cp0_wdata = 32'h0;
    endtask

    typedef struct {
        logic        sm, sw, fl, v;
        logic [4:0]  wa;
        logic        wreg;
        logic [31:0] dreg;
        logic        whilo;
        logic [63:0] hilo;
        logic        e_v;
        logic [4:0]  e_wa;
        logic        e_wreg;
        logic [31:0] e_dreg;
        logic        e_whilo;
        logic [63:0] e_hilo;
        logic [31:0] e_ret;
    } vec_t;

    localparam int NV = 12;
    vec_t tv[NV];

    initial begin
        //            sm    sw    fl    v     wa     wreg  dreg          whilo hilo                    e_v   e_wa   e_wreg e_dreg       e_whilo e_hilo                 e_ret
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 32'h1234_5678, 1'b0, 64'h0,                  1'b1, 5'd3,  1'b1, 32'h1234_5678, 1'b0, 64'h0,                  32'd0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 32'hDEAD_BEEF, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd7,  1'b1, 32'hDEAD_BEEF, 1'b1, 64'h0123_4567_89AB_CDEF, 32'd1};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 32'h1111_1111, 1'b1, 64'h1,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd2};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 64'h0,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd2};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 64'h0,                  1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 64'h0,                  32'd2};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 32'h0000_0001, 1'b1, 64'h5,                  1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 64'h0,                  32'd2};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2,  1'b1, 32'h0000_0002, 1'b0, 64'h0,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd2};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 32'h0000_0004, 1'b0, 64'h0,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd2};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0000_00FF, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, 5'd4,  1'b0, 32'h0000_00FF, 1'b1, 64'hFFFF_0000_FFFF_0000, 32'd2};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 32'h0000_0006, 1'b0, 64'h0,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd2};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 32'hA5A5_A5A5, 1'b0, 64'h0,                  1'b1, 5'd5,  1'b1, 32'hA5A5_A5A5, 1'b0, 64'h0,                  32'd2};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 32'h0000_0008, 1'b0, 64'h0,                  1'b0, 5'd0,  1'b0, 32'h0,          1'b0, 64'h0,                  32'd3};

        // Reset with random MEM inputs.
        rst = 1'b1; sm = 1'b0; sw = 1'b0; fl = 1'b0;
        clear_mem();
        m_valid = 1'b1; m_wa = 5'($urandom); m_wreg = 1'b1; m_dreg = $urandom;
        m_mreg = 1'b1; m_dre = 4'hF; m_whilo = 1'b1; m_hilo = {$urandom, $urandom};
        m_cp0_we = 1'b1; m_dm = $urandom;
        tick(); tick();
        chk("rst valid", bus.wb_valid_o, 1'b0);
        chk("rst wa", bus.wb_wa_o, 5'd0);
        chk("rst wreg", bus.wb_wreg_o, 1'b0);
        chk("rst dreg", bus.wb_dreg_o, 32'h0);
        chk("rst mreg", bus.wb_mreg_o, 1'b0);
        chk("rst whilo", bus.wb_whilo_o, 1'b0);
        chk("rst cp0_we", bus.wb_cp0_we_o, 1'b0);
        chk("rst retired", bus.retired_o, 32'd0);
        chk("rst dm_o", bus.dm_o, m_dm);
        rst = 1'b0;
        clear_mem();

        // Table-driven single-edge vectors.
        for (int i = 0; i < NV; i++) begin
            sm = tv[i].sm; sw = tv[i].sw; fl = tv[i].fl;
            m_valid = tv[i].v; m_wa = tv[i].wa; m_wreg = tv[i].wreg; m_dreg = tv[i].dreg;
            m_whilo = tv[i].whilo; m_hilo = tv[i].hilo;
            tick();
            chk($sformatf("vec%0d valid", i), bus.wb_valid_o, tv[i].e_v);
            chk($sformatf("vec%0d wa", i), bus.wb_wa_o, tv[i].e_wa);
            chk($sformatf("vec%0d wreg", i), bus.wb_wreg_o, tv[i].e_wreg);
            chk($sformatf("vec%0d dreg", i), bus.wb_dreg_o, tv[i].e_dreg);
            chk($sformatf("vec%0d whilo", i), bus.wb_whilo_o, tv[i].e_whilo);
            chk($sformatf("vec%0d hilo", i), bus.wb_hilo_o, tv[i].e_hilo);
            chk($sformatf("vec%0d retired", i), bus.retired_o, tv[i].e_ret);
        end
        sm = 1'b0; sw = 1'b0; fl = 1'b0;
        clear_mem();

        // Load word, then hold the RAM word across a 3-edge WB stall.
        m_valid = 1'b1; m_wa = 5'd8; m_wreg = 1'b1; m_mreg = 1'b1; m_dre = 4'hF; m_dm = 32'h0;
        tick();
        chk("load mreg", bus.wb_mreg_o, 1'b1);
        m_dm = 32'hAABB_CCDD; sw = 1'b1;
        tick();
        chk("hold capture", bus.dm_o, 32'hAABB_CCDD);
        m_dm = 32'h0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("hold dm_o %0d", k), bus.dm_o, 32'hAABB_CCDD);
            chk($sformatf("hold wa %0d", k), bus.wb_wa_o, 5'd8);
            chk($sformatf("hold mreg %0d", k), bus.wb_mreg_o, 1'b1);
            chk($sformatf("hold dre %0d", k), bus.wb_dre_o, 4'hF);
        end
        sw = 1'b0;
        tick();
        chk("unhold dm_o", bus.dm_o, 32'h0);

        // Flush wins over an active WB stall and drops the hold.
        sw = 1'b1; m_dm = 32'h1111_2222;
        tick();
        m_dm = 32'h3333_4444;
        #1;
        chk("pre-flush hold", bus.dm_o, 32'h1111_2222);
        fl = 1'b1;
        tick();
        chk("flush valid", bus.wb_valid_o, 1'b0);
        chk("flush wa", bus.wb_wa_o, 5'd0);
        chk("flush mreg", bus.wb_mreg_o, 1'b0);
        chk("flush wreg", bus.wb_wreg_o, 1'b0);
        chk("flush dm_o", bus.dm_o, 32'h3333_4444);
        fl = 1'b0; sw = 1'b0;
        clear_mem();

        // Signed byte load and CP0 fields pass straight through.
        m_valid = 1'b1; m_wa = 5'd10; m_wreg = 1'b1; m_mreg = 1'b1; m_dre = 4'b0100; m_sign = 1'b1;
        m_cp0_we = 1'b1; m_cp0_waddr = 5'd12; m_cp0_wdata = 32'h0000_0401;
        tick();
        chk("pt dre", bus.wb_dre_o, 4'b0100);
        chk("pt sign", bus.wb_sign_o, 1'b1);
        chk("pt cp0_we", bus.wb_cp0_we_o, 1'b1);
        chk("pt cp0_waddr", bus.wb_cp0_waddr_o, 5'd12);
        chk("pt cp0_wdata", bus.wb_cp0_wdata_o, 32'h0000_0401);
        chk("pt wa", bus.wb_wa_o, 5'd10);
        chk("pt retired", bus.retired_o, 32'd4);

        // Reset in the middle of a stall clears hold and the counter.
        sw = 1'b1; m_dm = 32'h0102_0304;
        tick();
        m_dm = 32'h0A0B_0C0D; rst = 1'b1;
        tick();
        chk("rst-stall dm_o", bus.dm_o, 32'h0A0B_0C0D);
        chk("rst-stall valid", bus.wb_valid_o, 1'b0);
        chk("rst-stall retired", bus.retired_o, 32'd0);
        chk("rst-stall retired4", bus4.retired_o, 4'd0);
        rst = 1'b0; sw = 1'b0;
        clear_mem();

        // Ten retirements, then two stalled edges.
        m_valid = 1'b1; m_wreg = 1'b1;
        for (int k = 0; k < 10; k++) begin
            m_wa = 5'(k + 1);
            tick();
        end
        m_valid = 1'b0; m_wreg = 1'b0;
        tick();
        sw = 1'b1;
        tick(); tick();
        chk("retire 10", bus.retired_o, 32'd10);
        chk("retire4 10", bus4.retired_o, 4'd10);
        sw = 1'b0;

        // Narrow counter instance wraps 15 -> 0.
        m_valid = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("retire 15", bus.retired_o, 32'd15);
        chk("retire4 15", bus4.retired_o, 4'd15);
        m_valid = 1'b0;
        tick();
        chk("retire 16", bus.retired_o, 32'd16);
        chk("retire4 wrap", bus4.retired_o, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
